wrap_row_buffer: RTL and testbench

WRAP_ROW_BUFFER -- requirements
Module: wrap_row_buffer

---
 rtl/wrap_row_buffer.sv | 166 ++++++++++++++++
 tb/tb_wrap_row_buffer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wrap_row_buffer.sv
// -----------------------------------------------------------------------------
// wrap_row_buffer
//
// Sits in front of a wrap stage (e.g. a circular-padding or line-wrap stage).
// Each frame is preceded by a replay of the last WRAP_Y rows of the previous
// frame. The first frame after reset has no previous frame, so its replay
// carries zeros instead.
//
// Per frame the block does two things in order:
//   1. REPLAY: it emits DEPTH = WRAP_Y*ITER_X beats on the wrap port.
//   2. PASS: it forwards IN_Y*ITER_X beats from data_in to data_out with
//      zero latency. While it forwards them, it captures the trailing WRAP_Y
//      rows for the next replay.
//
// Ports:
//   clk            : single clock. All state updates on the rising edge.
//   rst            : asynchronous, active-high reset.
//   data_in        : upstream beat of UNROLL_IN_X elements of IN_WIDTH bits.
//   data_in_valid  : upstream valid.
//   data_in_ready  : upstream ready. Follows data_out_ready in PASS.
//   data_out       : pass-through beat to the wrap stage data input.
//   data_out_valid : pass-through valid.
//   data_out_ready : pass-through ready.
//   wrap_out       : replayed beat to the wrap stage wrap input.
//   wrap_out_valid : replay valid.
//   wrap_out_ready : replay ready.
// -----------------------------------------------------------------------------
module wrap_row_buffer #(
    parameter int IN_WIDTH    = 32,
    parameter int WRAP_Y      = 1,
    parameter int IN_Y        = 2,
    parameter int IN_X        = 10,
    parameter int UNROLL_IN_X = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [IN_WIDTH*UNROLL_IN_X-1:0] data_in,
    input  logic                            data_in_valid,
    output logic                            data_in_ready,
    output logic [IN_WIDTH*UNROLL_IN_X-1:0] data_out,
    output logic                            data_out_valid,
    input  logic                            data_out_ready,
    output logic [IN_WIDTH*UNROLL_IN_X-1:0] wrap_out,
    output logic                            wrap_out_valid,
    input  logic                            wrap_out_ready
);

    localparam int BEAT_W = IN_WIDTH * UNROLL_IN_X;
    localparam int ITER_X = IN_X / UNROLL_IN_X;
    localparam int DEPTH  = WRAP_Y * ITER_X;
    localparam int IDX_W  = (DEPTH  > 1) ? $clog2(DEPTH)  : 1;
    localparam int X_W    = (ITER_X > 1) ? $clog2(ITER_X) : 1;
    localparam int Y_W    = (IN_Y   > 1) ? $clog2(IN_Y)   : 1;

    // Index of the first row that is kept for the next replay.
    localparam int WRAP_ROW0 = IN_Y - WRAP_Y;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [X_W-1:0]   LAST_X   = X_W'(ITER_X - 1);
    localparam logic [Y_W-1:0]   LAST_Y   = Y_W'(IN_Y - 1);

    typedef enum logic {
        REPLAY = 1'b0,
        PASS   = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] rd_idx, rd_idx_next;
    logic [X_W-1:0]   x, x_next;
    logic [Y_W-1:0]   y, y_next;
    logic             have_prev, have_prev_next;

    logic             buf_we;
    logic [IDX_W-1:0] wr_addr;
    logic [BEAT_W-1:0] buffer [DEPTH];

    // State register.
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples the pre-edge values, regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= REPLAY;
            rd_idx    <= '0;
            x         <= '0;
            y         <= '0;
            have_prev <= 1'b0;
        end else begin
            state     <= state_next;
            rd_idx    <= rd_idx_next;
            x         <= x_next;
            y         <= y_next;
            have_prev <= have_prev_next;
        end
    end

    // Next-state, counters and handshake outputs.
    // NOTE: every signal assigned here gets a default first. Without that,
    // a path that does not assign a signal would infer a latch.
    always_comb begin
        state_next     = state;
        rd_idx_next    = rd_idx;
        x_next         = x;
        y_next         = y;
        have_prev_next = have_prev;
        wrap_out_valid = 1'b0;
        data_out_valid = 1'b0;
        data_in_ready  = 1'b0;
        buf_we         = 1'b0;

        case (state)
            REPLAY: begin
                wrap_out_valid = 1'b1;
                if (wrap_out_ready) begin
                    if (rd_idx == LAST_IDX) begin
                        rd_idx_next = '0;
                        state_next  = PASS;
                    end else begin
                        rd_idx_next = rd_idx + 1'b1;
                    end
                end
            end

            PASS: begin
                data_out_valid = data_in_valid;
                data_in_ready  = data_out_ready;
                if (data_in_valid && data_out_ready) begin
                    buf_we = (int'(y) >= WRAP_ROW0);
                    if (x == LAST_X) begin
                        x_next = '0;
                        if (y == LAST_Y) begin
                            y_next         = '0;
                            have_prev_next = 1'b1;
                            state_next     = REPLAY;
                        end else begin
                            y_next = y + 1'b1;
                        end
                    end else begin
                        x_next = x + 1'b1;
                    end
                end
            end

            default: state_next = REPLAY;
        endcase
    end

    // Kept rows are stored in write order, so a replay simply walks 0..DEPTH-1.
    always_comb begin
        wr_addr = IDX_W'((int'(y) - WRAP_ROW0) * ITER_X + int'(x));
    end

    // NOTE: the buffer has no reset. Stale contents are never visible because
    // wrap_out is forced to zero until a full frame has been captured.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buffer[wr_addr] <= data_in;
        end
    end

    // Zero-latency pass-through. The valid and ready signals gate the beat.
    assign data_out = data_in;

    // Zeros until a full frame has been captured. The zeros also cover reset.
    assign wrap_out = (state == REPLAY && have_prev) ? buffer[rd_idx] : '0;

endmodule

// File: tb/tb_wrap_row_buffer.sv
// -----------------------------------------------------------------------------
// tb_wrap_row_buffer
//
// Scoreboard bench for wrap_row_buffer.
//   dut  : default parameters (ITER_X=2, WRAP_Y=1, DEPTH=2).
//   dut2 : WRAP_Y=IN_Y=2 (DEPTH=4). The whole frame is replayed.
//
// Drivers push expected beats into queues when they issue stimulus. A monitor
// per instance pops and compares on each handshake. While an output is
// stalled, the monitor checks the presented beat against the queue head.
// -----------------------------------------------------------------------------
module tb_wrap_row_buffer;

    localparam int W = 32 * 5;

    logic clk;
    logic rst;

    logic [W-1:0] data_in, data_out, wrap_out;
    logic         data_in_valid, data_in_ready;
    logic         data_out_valid, data_out_ready;
    logic         wrap_out_valid, wrap_out_ready;

    logic [W-1:0] d2_data_in, d2_data_out, d2_wrap_out;
    logic         d2_data_in_valid, d2_data_in_ready;
    logic         d2_data_out_valid, d2_data_out_ready;
    logic         d2_wrap_out_valid, d2_wrap_out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_wrap[$];
    logic [W-1:0] exp_data[$];
    logic [W-1:0] exp_wrap2[$];
    logic [W-1:0] exp_data2[$];

    // Frame model for dut: beat position within the frame and captured beats.
    int           beat_no  = 0;
    logic [W-1:0] frame_buf [4];
    int           beat_no2 = 0;
    logic [W-1:0] frame_buf2 [4];

    bit rand_ready = 0;

    wrap_row_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .wrap_out       (wrap_out),
        .wrap_out_valid (wrap_out_valid),
        .wrap_out_ready (wrap_out_ready)
    );

    wrap_row_buffer #(
        .IN_WIDTH(32), .WRAP_Y(2), .IN_Y(2), .IN_X(10), .UNROLL_IN_X(5)
    ) dut2 (
        .clk            (clk),
        .rst            (rst),
        .data_in        (d2_data_in),
        .data_in_valid  (d2_data_in_valid),
        .data_in_ready  (d2_data_in_ready),
        .data_out       (d2_data_out),
        .data_out_valid (d2_data_out_valid),
        .data_out_ready (d2_data_out_ready),
        .wrap_out       (d2_wrap_out),
        .wrap_out_valid (d2_wrap_out_valid),
        .wrap_out_ready (d2_wrap_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk_beat(input int tag);
        logic [W-1:0] b;
        for (int k = 0; k < 5; k++) b[k*32 +: 32] = 32'(tag * 256 + k);
        return b;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not seen as expected", name);
    endtask

    // Ready generator: both readies are held at 1 unless random toggling is on.
    initial begin
        data_out_ready    = 1'b1;
        wrap_out_ready    = 1'b1;
        d2_data_out_ready = 1'b1;
        d2_wrap_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) begin
                data_out_ready = 1'($urandom_range(0, 1));
                wrap_out_ready = 1'($urandom_range(0, 1));
            end else begin
                data_out_ready = 1'b1;
                wrap_out_ready = 1'b1;
            end
        end
    end

    // Monitor for dut. Inputs settle at posedge+1, so a handshake seen at
    // the negedge completes on the following posedge.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (wrap_out_valid) begin
                if (exp_wrap.size() == 0) fail_now("wrap_unexpected");
                else if (wrap_out_ready) check("wrap_beat", wrap_out, exp_wrap.pop_front());
                else check("wrap_stall", wrap_out, exp_wrap[0]);
            end
            if (data_out_valid) begin
                if (exp_data.size() == 0) fail_now("data_unexpected");
                else if (data_out_ready) check("data_beat", data_out, exp_data.pop_front());
                else check("data_stall", data_out, exp_data[0]);
            end
            if (wrap_out_valid && data_in_valid)
                check("replay_blocks_input", W'({data_in_ready, data_out_valid}), '0);
        end
    end

    // Monitor for dut2. Both of its readies are always high.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (d2_wrap_out_valid && d2_wrap_out_ready) begin
                if (exp_wrap2.size() == 0) fail_now("wrap2_unexpected");
                else check("wrap2_beat", d2_wrap_out, exp_wrap2.pop_front());
            end
            if (d2_data_out_valid && d2_data_out_ready) begin
                if (exp_data2.size() == 0) fail_now("data2_unexpected");
                else check("data2_beat", d2_data_out, exp_data2.pop_front());
            end
        end
    end

    // Present one beat to dut. The next replay is queued on the last beat of a
    // frame: the last row (beats 2,3) of that frame.
    task automatic send(input logic [W-1:0] b);
        bit ok = 0;
        exp_data.push_back(b);
        frame_buf[beat_no] = b;
        if (beat_no == 3) begin
            exp_wrap.push_back(frame_buf[2]);
            exp_wrap.push_back(frame_buf[3]);
        end
        beat_no = (beat_no + 1) % 4;
        data_in       = b;
        data_in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (data_in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!ok) fail_now("send_timeout");
    endtask

    // Present one beat to dut2. Its whole frame is replayed.
    task automatic send2(input logic [W-1:0] b);
        bit ok = 0;
        exp_data2.push_back(b);
        frame_buf2[beat_no2] = b;
        if (beat_no2 == 3) begin
            for (int k = 0; k < 4; k++) exp_wrap2.push_back(frame_buf2[k]);
        end
        beat_no2 = (beat_no2 + 1) % 4;
        d2_data_in       = b;
        d2_data_in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (d2_data_in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!ok) fail_now("send2_timeout");
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (exp_wrap.size() == 0 && exp_data.size() == 0 &&
                exp_wrap2.size() == 0 && exp_data2.size() == 0) break;
            @(negedge clk);
        end
        check({name, "_wrap_left"},  W'(exp_wrap.size()),  '0);
        check({name, "_data_left"},  W'(exp_data.size()),  '0);
        check({name, "_wrap2_left"}, W'(exp_wrap2.size()), '0);
        check({name, "_data2_left"}, W'(exp_data2.size()), '0);
    endtask

    // After reset both instances replay zeros: DEPTH=2 for dut, 4 for dut2.
    task automatic queue_reset_replay();
        beat_no  = 0;
        beat_no2 = 0;
        repeat (2) exp_wrap.push_back('0);
        repeat (4) exp_wrap2.push_back('0);
    endtask

    initial begin
        rst              = 1'b1;
        data_in          = '0;
        data_in_valid    = 1'b0;
        d2_data_in       = '0;
        d2_data_in_valid = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_wrap_valid", W'(wrap_out_valid), W'(1));
        check("rst_wrap_out",   wrap_out,           '0);
        check("rst_data_valid", W'(data_out_valid), '0);
        check("rst_in_ready",   W'(data_in_ready),  '0);
        check("rst2_wrap_out",  d2_wrap_out,        '0);
        queue_reset_replay();
        rst = 1'b0;

        // dut2 with DEPTH=4: frame A is replayed as A0,A1,A2,A3.
        for (int i = 0; i < 4; i++) send2(mk_beat('h50 + i));
        d2_data_in_valid = 1'b0;

        // dut: frames A and B with ready held high, then C with random stalls.
        // Input stays valid across each replay, so the replay must block it.
        for (int i = 0; i < 4; i++) send(mk_beat('hA0 + i));
        for (int i = 0; i < 4; i++) send(mk_beat('hB0 + i));
        rand_ready = 1;
        for (int i = 0; i < 4; i++) send(mk_beat('hC0 + i));
        data_in_valid = 1'b0;
        drain("frames");
        rand_ready = 0;
        repeat (2) @(posedge clk);
        #1;

        // Mid-frame reset after D0,D1. The following replay must be zeros.
        send(mk_beat('hD0));
        send(mk_beat('hD1));
        data_in_valid = 1'b0;
        exp_data.delete();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_wrap_valid", W'(wrap_out_valid), W'(1));
        check("async_rst_wrap_out",   wrap_out,           '0);
        check("async_rst_in_ready",   W'(data_in_ready),  '0);
        check("async_rst_data_valid", W'(data_out_valid), '0);
        repeat (2) @(posedge clk);
        #1;
        queue_reset_replay();
        rst = 1'b0;

        // Frame E after reset. A full frame must be needed before the next
        // replay, and that replay must carry E2,E3.
        for (int i = 0; i < 4; i++) send(mk_beat('hE0 + i));
        data_in_valid = 1'b0;
        drain("after_reset");

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
